// File: rtl/dff_arb_pkg.sv
// Shared definitions for the dff_write_arbiter slice: FSM state type,
// pointer-width helper and default parameter values.
// Optional burst writes are enabled by defining DFF_ARB_BURST_EN.
package dff_arb_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 8;

    // Explicit encodings keep the state register layout identical to the
    // legacy localparam-based implementation.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_COMMIT = 2'd2
    } arb_state_e;

    // Width of a requester index / round-robin pointer (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dff_write_arbiter_rr_pick.sv
// rr_pick: combinational rotate-and-priority-encode.
// Returns the first asserted request scanning upward from ptr+1, wrapping
// modulo N_REQ. The requester at ptr itself is checked last.
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned PW    = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    winner,
    output logic             valid
);

    // Scan offsets from farthest to nearest so the nearest asserted request
    // is the last assignment and therefore wins.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            idx = 32'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req[PW'(idx)]) begin
                winner = PW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: round-robin arbiter sharing one WIDTH-bit holding
// register among N_REQ requesters. IDLE picks a winner, GRANT writes the
// winner's data and pulses ack, COMMIT is a one-cycle recovery slot.
// Define DFF_ARB_BURST_EN to add the lock input for back-to-back writes.
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned       N_REQ   = DEF_N_REQ,
    parameter int unsigned       WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0]  Q_RESET = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   wr_data,
`ifdef DFF_ARB_BURST_EN
    input  logic [N_REQ-1:0]         lock,
`endif
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         ack,
    output logic                     busy,
    output logic [WIDTH-1:0]         q
);

    localparam int unsigned PW = ptr_width(N_REQ);

    arb_state_e         state_q, state_d;
    logic [PW-1:0]      ptr_q,   ptr_d;
    logic [PW-1:0]      win_q,   win_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q,   ack_d;
    logic [WIDTH-1:0]   data_q,  data_d;

    logic [PW-1:0]      pick_idx;
    logic               pick_vld;
    logic [N_REQ-1:0]   pick_oh;
    logic [N_REQ-1:0]   win_oh;
    logic [WIDTH-1:0]   win_data;
    logic               win_req;
    logic               win_lock;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    // Decode the held winner and the fresh pick into one-hot form, and mux
    // out the winner's request, lock and data lane.
    always_comb begin
        pick_oh  = '0;
        win_oh   = '0;
        win_data = '0;
        win_req  = 1'b0;
        win_lock = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx == PW'(i)) begin
                pick_oh[i] = 1'b1;
            end
            if (win_q == PW'(i)) begin
                win_oh[i] = 1'b1;
                win_data  = wr_data[i*WIDTH +: WIDTH];
                win_req   = req[i];
`ifdef DFF_ARB_BURST_EN
                win_lock  = lock[i];
`endif
            end
        end
    end

    // FSM next-state: arbitration in IDLE, write or abort in GRANT.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = '0;
        ack_d   = '0;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    win_d   = pick_idx;
                    grant_d = pick_oh;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (win_req) begin
                    data_d = win_data;
                    ack_d  = win_oh;
                    if (win_lock) begin
                        // Burst word: keep grant, hold the pointer until
                        // the final (unlocked) word.
                        grant_d = win_oh;
                    end else begin
                        ptr_d   = win_q;
                        state_d = ST_COMMIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(N_REQ - 1);
            win_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            data_q  <= Q_RESET;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
        end
    end

    assign grant = grant_q;
    assign ack   = ack_q;
    assign busy  = (state_q != ST_IDLE);
    assign q     = data_q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed self-checking bench for dff_write_arbiter (N_REQ=4, WIDTH=8).
// Define DFF_ARB_BURST_EN to include the burst sequence.
module tb_dff_write_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] wr_data;
`ifdef DFF_ARB_BURST_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           busy;
    logic [W-1:0]   q;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dff_write_arbiter #(
        .N_REQ   (N),
        .WIDTH   (W),
        .Q_RESET (8'h00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr_data (wr_data),
`ifdef DFF_ARB_BURST_EN
        .lock    (lock),
`endif
        .grant   (grant),
        .ack     (ack),
        .busy    (busy),
        .q       (q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                           input logic eb, input logic [7:0] eq);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".ack"},   32'(ack),   32'(ea));
        chk({tag, ".busy"},  32'(busy),  32'(eb));
        chk({tag, ".q"},     32'(q),     32'(eq));
    endtask

    task automatic set_lane(input int unsigned i, input logic [7:0] d);
        wr_data[i*W +: W] = d;
    endtask

    logic [7:0] exp_q [5];
    logic [3:0] exp_g [5];

    initial begin
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst = 1'b1; req = '0; wr_data = '0;
`ifdef DFF_ARB_BURST_EN
        lock = '0;
`endif
        tick(); tick();
        chk_all("reset", 4'b0000, 4'b0000, 1'b0, 8'h00);
        rst = 1'b0;
        tick();
        chk_all("idle", 4'b0000, 4'b0000, 1'b0, 8'h00);

        // Contention: all four hold requests; pointer starts at 3.
        set_lane(0, 8'h10); set_lane(1, 8'h11); set_lane(2, 8'h12); set_lane(3, 8'h13);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_all("cont.grant", exp_g[k], 4'b0000, 1'b1, (k == 0) ? 8'h00 : exp_q[k-1]);
            tick();
            if (k == 4) req = 4'b0000;
            chk_all("cont.ack", 4'b0000, exp_g[k], 1'b1, exp_q[k]);
            tick();
            chk_all("cont.commit", 4'b0000, 4'b0000, 1'b0, exp_q[k]);
        end

        // Single requester 2 (pointer now 0).
        set_lane(2, 8'h3C);
        req = 4'b0100;
        tick();
        chk_all("single.e1", 4'b0100, 4'b0000, 1'b1, 8'h10);
        tick();
        chk_all("single.e2", 4'b0000, 4'b0100, 1'b1, 8'h3C);
        req = 4'b0000;
        tick();
        chk_all("single.e3", 4'b0000, 4'b0000, 1'b0, 8'h3C);

        // Rotation: pointer at 2, req 0101 -> scan 3,0 -> requester 0 first.
        set_lane(0, 8'h50); set_lane(2, 8'h52);
        req = 4'b0101;
        tick();
        chk_all("rot.g0", 4'b0001, 4'b0000, 1'b1, 8'h3C);
        tick();
        chk_all("rot.a0", 4'b0000, 4'b0001, 1'b1, 8'h50);
        req = 4'b0100;
        tick();
        tick();
        chk_all("rot.g2", 4'b0100, 4'b0000, 1'b1, 8'h50);
        tick();
        chk_all("rot.a2", 4'b0000, 4'b0100, 1'b1, 8'h52);
        req = 4'b0000;
        tick();

        // Withdraw during GRANT: no write, pointer stays at 2.
        set_lane(0, 8'h77);
        req = 4'b0001;
        tick();
        chk_all("wd.grant", 4'b0001, 4'b0000, 1'b1, 8'h52);
        req = 4'b0000;
        tick();
        chk_all("wd.abort", 4'b0000, 4'b0000, 1'b0, 8'h52);
        set_lane(0, 8'h60); set_lane(1, 8'h61);
        req = 4'b0011;
        tick();
        chk_all("wd.regrant", 4'b0001, 4'b0000, 1'b1, 8'h52);
        tick();
        chk_all("wd.write", 4'b0000, 4'b0001, 1'b1, 8'h60);
        req = 4'b0000;
        tick();

`ifdef DFF_ARB_BURST_EN
        // Burst from requester 1: four words, one per cycle.
        set_lane(1, 8'h01);
        req = 4'b0010; lock = 4'b0010;
        tick();
        chk_all("burst.grant", 4'b0010, 4'b0000, 1'b1, 8'h60);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_all("burst.word", 4'b0010, 4'b0010, 1'b1, 8'(k));
            set_lane(1, 8'(k + 1));
        end
        lock = 4'b0000;
        tick();
        chk_all("burst.last", 4'b0000, 4'b0010, 1'b1, 8'h04);
        req = 4'b0000;
        tick();
        chk_all("burst.idle", 4'b0000, 4'b0000, 1'b0, 8'h04);
`endif

        // Reset asserted mid-GRANT drops the pending write at once.
        set_lane(1, 8'hA5);
        req = 4'b0010;
        tick();
        chk("rstmid.grant", 32'(grant), 32'(4'b0010));
        rst = 1'b1;
        #1;
        chk_all("rstmid.async", 4'b0000, 4'b0000, 1'b0, 8'h00);
        req = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        chk_all("rstmid.after1", 4'b0000, 4'b0000, 1'b0, 8'h00);
        tick();
        chk_all("rstmid.after2", 4'b0000, 4'b0000, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dff_write_arbiter.md
Name: dff_write_arbiter

Overview:
- Round-robin controller that shares one WIDTH-bit D-flip-flop holding register among N_REQ requesters.
- Each requester raises a request with its data. The arbiter grants one requester at a time, captures that requester's data into the shared register, and acknowledges it.
- Sits between multiple producers and any consumer of the shared register output q.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, data width of each requester's data and of the shared register
- Q_RESET, 0, reset value of the shared register q

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- req  input  N_REQ  per-requester write request, level
- wr_data  input  N_REQ*WIDTH  flattened data; requester i occupies bits [i*WIDTH +: WIDTH]
- grant  output  N_REQ  one-hot grant, registered
- ack  output  N_REQ  one-hot single-cycle write acknowledge, registered
- busy  output  1  high whenever the FSM is not IDLE
- q  output  WIDTH  shared register contents

Behaviour:
- Reset is asynchronous and active-high: grant=0, ack=0, busy=0, q=Q_RESET, state=IDLE, rr pointer=N_REQ-1 (so requester 0 has priority first).
- FSM states:
  - IDLE:
    - If req is nonzero, select the winner: the first asserted req scanning upward from pointer+1, modulo N_REQ.
    - Register grant[winner]=1 and go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT:
    - If req[winner]=1: load q from wr_data[winner], assert ack[winner]=1 for the next cycle, set pointer=winner, clear grant, go to COMMIT.
    - If req[winner]=0 (requester withdrew): abort. No write, no ack, pointer unchanged, clear grant, go to IDLE.
  - COMMIT:
    - ack is high this cycle only; go to IDLE.
    - A request present in this cycle is not arbitrated until IDLE.
- Latency: req sampled at edge n, grant high from edge n+1, q and ack updated at edge n+2, ack low at edge n+3. Minimum cycles between two writes is 3.
- The requester must hold req and wr_data stable until it sees ack. It drops req in the ack cycle or later.
  - If req is still high in IDLE after ack, the requester re-competes normally; rotation guarantees the others go first.
- grant and ack are always one-hot or zero. They are never high in the same cycle.
- Fairness: with all requesters continuously asserting, the write order is 0,1,…,N_REQ-1,0,…; no starvation.
- Reset asserted mid-operation (GRANT or COMMIT) forces the reset values immediately. A pending write is dropped and q=Q_RESET.
- Simultaneous requests are resolved only by the rotating pointer; there is no fixed priority.

Optional Feature:
- Macro: DFF_ARB_BURST_EN
- Defined: adds input lock (N_REQ bits).
  - In GRANT, if lock[winner]=1 and req[winner]=1: write q, pulse ack[winner], and stay in GRANT with grant held. This gives one write per cycle.
  - Dropping lock writes the final word and proceeds to COMMIT as normal.
  - The pointer updates on the final word only.
- Undefined: no lock port; behaviour exactly as above.

Decomposition:
- Package dff_arb_pkg:
  - state enum (IDLE, GRANT, COMMIT)
  - pointer-width function ($clog2(N_REQ))
  - default constants
- One sub-module, rr_pick: combinational rotate-and-priority-encode. Inputs are req and pointer; outputs are winner index and valid. It is reusable by other arbiters.

Test Plan:
- Reset check: assert rst mid-GRANT with req=4'b0010 and wr_data[1]=8'hA5 → grant/ack/busy=0 and q=8'h00 immediately; no ack after release.
- Single requester: req=4'b0100, wr_data[2]=8'h3C at edge 0 → grant=4'b0100 at edge 1, q=8'h3C with ack=4'b0100 at edge 2, ack=0 at edge 3.
- Contention: req=4'b1111 held with data 8'h10,8'h11,8'h12,8'h13 → q sequence 10,11,12,13,10 with acks every 3 cycles.
- Rotation: after requester 2 wins, req=4'b0101 → requester 0 is granted, because the scan goes 3 then 0.
- Withdraw: req=4'b0001 dropped during GRANT → no ack, q unchanged, the next req=4'b0011 grants requester 0 (pointer unchanged).
- Burst (DFF_ARB_BURST_EN): requester 1 with lock high for 4 cycles and data 8'h01..8'h04 → q updates every cycle, 4 ack pulses, grant continuously high.
